// File: rtl/seq_window_detector.sv
// Detects a programmable 3-bit pattern on the {q2,q1,q0} window of an upstream shift register,
// discarding startup fill samples, with a registered match pulse and a saturating match counter.
module seq_window_detector #(
    parameter logic [2:0]  PATTERN  = 3'b101,
    parameter int unsigned OVERLAP  = 1,
    parameter int unsigned FILL_LEN = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             q0,
    input  logic             q1,
    input  logic             q2,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             armed
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [2:0]       FILL_LAST = 3'(FILL_LEN - 1);

    state_t           state;
    logic [2:0]       fill_cnt;
    logic             hold_cnt;
    logic             hit;
    logic [CNT_W-1:0] count_inc;

    // Comparator is gated by state so window contents during FILL never reach the outputs.
    always_comb begin
        hit       = 1'b0;
        count_inc = count;
        if (state == ARMED && en && ({q2, q1, q0} == PATTERN)) begin
            hit = 1'b1;
        end
        if (count != CNT_MAX) begin
            count_inc = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            fill_cnt <= '0;
            hold_cnt <= 1'b0;
            match    <= 1'b0;
            count    <= '0;
            sat      <= 1'b0;
            armed    <= 1'b0;
        end else begin
            match <= hit;

            if (clr) begin
                count <= '0;
                sat   <= 1'b0;
            end else if (hit) begin
                count <= count_inc;
                sat   <= (count_inc == CNT_MAX);
            end

            if (en) begin
                case (state)
                    FILL: begin
                        fill_cnt <= fill_cnt + 3'd1;
                        if (fill_cnt == FILL_LAST) begin
                            state <= ARMED;
                            armed <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (hit && OVERLAP == 0) begin
                            state    <= HOLD;
                            hold_cnt <= 1'b0;
                            armed    <= 1'b0;
                        end
                    end
                    HOLD: begin
                        // Second skipped sample wraps hold_cnt back to 0 and re-arms.
                        hold_cnt <= ~hold_cnt;
                        if (hold_cnt) begin
                            state <= ARMED;
                            armed <= 1'b1;
                        end
                    end
                    default: begin
                        state <= FILL;
                        armed <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_window_detector.sv
// Scoreboard bench: four differently-parameterised detectors share one stimulus stream and are
// checked every cycle against a sample-index based reference model.
module tb_seq_window_detector;

    localparam int NI = 4;
    localparam logic [2:0] PAT  [NI] = '{3'b101, 3'b101, 3'b101, 3'b011};
    localparam int         OVL  [NI] = '{1, 0, 1, 0};
    localparam int         FL   [NI] = '{3, 3, 3, 5};
    localparam int         CMAX [NI] = '{15, 15, 3, 7};

    logic clk, rst, en, q0, q1, q2, clr;

    logic       m0, s0, a0, m1, s1, a1, m2, s2, a2, m3, s3, a3;
    logic [3:0] c0, c1;
    logic [1:0] c2;
    logic [2:0] c3;
    logic [6:0] act [NI];

    assign act[0] = {m0, s0, a0, c0};
    assign act[1] = {m1, s1, a1, c1};
    assign act[2] = {m2, s2, a2, 2'b00, c2};
    assign act[3] = {m3, s3, a3, 1'b0, c3};

    seq_window_detector #(.PATTERN(3'b101), .OVERLAP(1), .FILL_LEN(3), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .en(en), .q0(q0), .q1(q1), .q2(q2), .clr(clr),
        .match(m0), .count(c0), .sat(s0), .armed(a0));
    seq_window_detector #(.PATTERN(3'b101), .OVERLAP(0), .FILL_LEN(3), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .en(en), .q0(q0), .q1(q1), .q2(q2), .clr(clr),
        .match(m1), .count(c1), .sat(s1), .armed(a1));
    seq_window_detector #(.PATTERN(3'b101), .OVERLAP(1), .FILL_LEN(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .q0(q0), .q1(q1), .q2(q2), .clr(clr),
        .match(m2), .count(c2), .sat(s2), .armed(a2));
    seq_window_detector #(.PATTERN(3'b011), .OVERLAP(0), .FILL_LEN(5), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .q0(q0), .q1(q1), .q2(q2), .clr(clr),
        .match(m3), .count(c3), .sat(s3), .armed(a3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: samples are numbered since reset; a sample is compared only when its
    // index has reached next_ok, and a non-overlapping match pushes next_ok three samples on.
    int nsamp [NI];
    int next_ok [NI];
    int cnt [NI];

    logic [7*NI-1:0] sb [$];
    int   total = 0;
    int   bad   = 0;
    logic started = 1'b0;
    logic done    = 1'b0;
    int   cyc     = 0;

    task automatic model(input logic r, input logic e, input logic [2:0] w, input logic c);
        logic [7*NI-1:0] ev;
        logic m, s, a;
        ev = '0;
        for (int i = 0; i < NI; i++) begin
            m = 1'b0;
            if (r) begin
                nsamp[i]   = 0;
                next_ok[i] = FL[i] + 1;
                cnt[i]     = 0;
            end else begin
                if (e) begin
                    nsamp[i]++;
                    if (nsamp[i] >= next_ok[i] && w == PAT[i]) begin
                        m = 1'b1;
                        if (OVL[i] == 0) next_ok[i] = nsamp[i] + 3;
                        if (cnt[i] < CMAX[i]) cnt[i]++;
                    end
                end
                if (c) cnt[i] = 0;
            end
            a = (nsamp[i] + 1 >= next_ok[i]);
            s = (cnt[i] == CMAX[i]);
            ev[i*7 +: 7] = {m, s, a, cnt[i][3:0]};
        end
        sb.push_back(ev);
        started = 1'b1;
    endtask

    task automatic step(input logic r, input logic e, input logic [2:0] w, input logic c);
        @(negedge clk);
        rst = r;
        en  = e;
        {q2, q1, q0} = w;
        clr = c;
        model(r, e, w, c);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 3'b000, 1'b0);
        step(1'b1, 1'b1, 3'b101, 1'b1);
    endtask

    // Monitor: every cycle the DUTs present their registered outputs.
    initial begin
        logic [7*NI-1:0] ev;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (sb.size() > 0) begin
                ev = sb.pop_front();
                for (int i = 0; i < NI; i++) begin
                    total++;
                    if (act[i] !== ev[i*7 +: 7]) begin
                        bad++;
                        $display("FAIL outputs dut%0d cycle %0d: got m/s/a/count=%b/%b/%b/%0d want %b/%b/%b/%0d",
                                 i, cyc, act[i][6], act[i][5], act[i][4], act[i][3:0],
                                 ev[i*7+6], ev[i*7+5], ev[i*7+4], ev[i*7 +: 4]);
                    end
                end
            end else if (started && !done) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow cycle %0d: got empty queue want entry", cyc);
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0; {q2, q1, q0} = 3'b000;

        // Fill discard then first detection
        do_reset();
        repeat (4) step(1'b0, 1'b1, 3'b101, 1'b0);

        // Overlap / non-overlap pattern
        do_reset();
        repeat (3) step(1'b0, 1'b1, 3'b000, 1'b0);
        step(1'b0, 1'b1, 3'b101, 1'b0);
        step(1'b0, 1'b1, 3'b010, 1'b0);
        step(1'b0, 1'b1, 3'b101, 1'b0);
        step(1'b0, 1'b1, 3'b101, 1'b0);
        do_reset();
        repeat (3) step(1'b0, 1'b1, 3'b111, 1'b0);
        repeat (4) step(1'b0, 1'b1, 3'b101, 1'b0);

        // en gaps
        do_reset();
        repeat (3) step(1'b0, 1'b1, 3'b011, 1'b0);
        repeat (5) step(1'b0, 1'b0, 3'b101, 1'b0);
        step(1'b0, 1'b1, 3'b101, 1'b0);
        repeat (2) step(1'b0, 1'b0, 3'b101, 1'b0);

        // Saturation, then clr coinciding with a match
        do_reset();
        repeat (3) step(1'b0, 1'b1, 3'b101, 1'b0);
        repeat (5) step(1'b0, 1'b1, 3'b101, 1'b0);
        step(1'b0, 1'b1, 3'b101, 1'b1);
        step(1'b0, 1'b0, 3'b101, 1'b0);

        // Reset in the middle of HOLD, then fill again
        do_reset();
        repeat (3) step(1'b0, 1'b1, 3'b000, 1'b0);
        step(1'b0, 1'b1, 3'b101, 1'b0);
        step(1'b0, 1'b1, 3'b101, 1'b0);
        step(1'b1, 1'b1, 3'b101, 1'b0);
        repeat (4) step(1'b0, 1'b1, 3'b101, 1'b0);

        // Randomized traffic with a bias towards the detected patterns
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] w;
            logic r, e, c;
            case ($urandom_range(0, 3))
                0:       w = 3'b101;
                1:       w = 3'b011;
                default: w = 3'($urandom_range(0, 7));
            endcase
            r = ($urandom_range(0, 99) < 1);
            e = ($urandom_range(0, 99) < 70);
            c = ($urandom_range(0, 99) < 3);
            step(r, e, w, c);
        end

        done = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_window_detector.md
Name: seq_window_detector

Overview:
- Downstream consumer of the 3-tap serial shift register (serial input a, taps q0/q1/q2).
- Samples the 3-bit window {q2,q1,q0} on enabled cycles and detects a programmable 3-bit pattern. q2 is the oldest bit and q0 the newest.
- Emits a registered match pulse and keeps a saturating match count.
- Discards the startup samples taken while the unreset shift register is still filling.

Parameters:
- PATTERN, 3'b101, target window compared against {q2,q1,q0}.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = after a match, skip the next 2 enabled samples.
- FILL_LEN, 3, number of enabled samples discarded after reset (range 1..7).
- CNT_W, 4, width of the match counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample qualifier; high when the upstream register shifted this cycle.
- q0  in  1  newest window bit.
- q1  in  1  middle window bit.
- q2  in  1  oldest window bit.
- clr  in  1  synchronous clear of count and sat only.
- match  out  1  one-cycle pulse, registered.
- count  out  CNT_W  saturating number of matches.
- sat  out  1  high while count == 2^CNT_W-1.
- armed  out  1  high in state ARMED.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high; the reset polarity and synchronicity are fixed.
- Reset: on a rising edge with rst=1, the block enters state=FILL with fill_cnt=0, hold_cnt=0, match=0, count=0, sat=0, armed=0. rst overrides en, clr and everything else, including a reset in the middle of FILL or HOLD.
- Sample: a rising edge with en=1 and rst=0. With en=0 the FSM, fill_cnt and hold_cnt hold their values and match=0 on the next cycle.
- FILL state:
  - Each sample increments fill_cnt; the window is not compared.
  - On the sample that makes fill_cnt==FILL_LEN, the FSM goes to ARMED.
  - The first compared sample is sample number FILL_LEN+1.
- ARMED state:
  - A sample with {q2,q1,q0}==PATTERN sets match=1 for exactly the following cycle and increments count.
  - If OVERLAP=0, the FSM goes to HOLD with hold_cnt=0. If OVERLAP=1, it stays in ARMED.
- HOLD state (OVERLAP=0 only):
  - Each sample increments hold_cnt and is not compared.
  - On the 2nd sample the FSM returns to ARMED.
  - armed=0 throughout HOLD.
- Latency: 1 clock. The window sampled at edge k produces match high between edges k and k+1. match is 0 on every cycle not directly after a matching sample.
- Counter:
  - count increments by 1 per match and saturates at 2^CNT_W-1; it never wraps.
  - sat = (count==2^CNT_W-1), registered together with count.
- clr:
  - On the edge with clr=1, count is set to 0 and sat to 0.
  - The FSM, match and armed are unaffected.
  - clr together with a matching sample: clr wins, so count=0, but match still pulses.
- X-safety: window values during FILL must not affect any output (the comparator result is gated by state).

Test Plan:
- Fill discard: rst for 2 cycles, then 3 samples with window 101 → match stays 0, count=0, armed goes to 1 after the 3rd sample. A 4th sample with 101 → match=1 for one cycle, count=1.
- Overlap (OVERLAP=1): after fill, windows 101, 010, 101, 101 → match on the 1st, 3rd and 4th samples, count=3.
- Non-overlap (OVERLAP=0): after fill, windows 101, 101, 101, 101 → match on the 1st and 4th samples only, armed=0 during the 2nd and 3rd, count=2.
- en gaps: after fill, window 101 held with en=0 for 5 cycles → no match and no count change. Then en=1 for one cycle → exactly one match pulse.
- Saturation/clr (CNT_W=2): 5 matching samples → count 1,2,3,3,3 and sat=1 from the 3rd. clr on the same edge as a 6th match → count=0, sat=0, match=1.
- Reset mid-HOLD (OVERLAP=0): after a match, assert rst during HOLD → next cycle state=FILL, count=0, armed=0. Then 3 more samples are discarded before detection resumes.
